// File: rtl/seq_gen_if.sv
// seq_gen_if: pin-side bundle of the sequence generator core.
// The master drives the controls; the slave is the core.
interface seq_gen_if #(
    parameter int WIDTH = 8
);
    logic [2:0]       mode_i;
    logic [3:0]       div_sel_i;
    logic             run_i;
    logic             step_i;
    logic             restart_i;
    logic [WIDTH-1:0] value_o;
    logic [WIDTH-1:0] index_o;
    logic             valid_o;
    logic             ovf_o;

    modport master (
        output mode_i, div_sel_i, run_i, step_i, restart_i,
        input  value_o, index_o, valid_o, ovf_o
    );

    modport slave (
        input  mode_i, div_sel_i, run_i, step_i, restart_i,
        output value_o, index_o, valid_o, ovf_o
    );
endinterface

// File: rtl/seq_gen_core.sv
// seq_gen_core: eight integer sequences mod 2^WIDTH with term index,
// sticky overflow and update-valid pulse; divider or manual stepping.
module seq_gen_core #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 18
) (
    input  logic     clk,
    input  logic     reset,
    seq_gen_if.slave sg
);
    localparam int FW = 2 * WIDTH + 2;

    localparam logic [2:0] M_SQ    = 3'd0;
    localparam logic [2:0] M_POW3  = 3'd1;
    localparam logic [2:0] M_TRI   = 3'd2;
    localparam logic [2:0] M_FIB   = 3'd3;
    localparam logic [2:0] M_PELL  = 3'd4;
    localparam logic [2:0] M_LUCAS = 3'd5;
    localparam logic [2:0] M_PAD   = 3'd6;
    localparam logic [2:0] M_SYL   = 3'd7;

    logic [2:0]       mode_q;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic [WIDTH-1:0] idx_q, idx_d;
    logic             fb_q, fb_d, fc_q, fc_d;
    logic             ovf_q, ovf_d, valid_q, valid_d;
    logic [DIV_W-1:0] cnt_q, cnt_d, pm1;
    logic [WIDTH-1:0] i_a, i_b, i_c, bm1;
    logic [FW-1:0]    full;
    logic             carry, tick, adv, rst_seq;

    // Term-0 state of the requested mode (reset, restart, mode change)
    always_comb begin
        i_a = '0;
        i_b = '0;
        i_c = '0;
        case (sg.mode_i)
            M_POW3:  i_a = WIDTH'(1);
            M_FIB:   begin i_a = WIDTH'(1); i_b = WIDTH'(1); end
            M_PELL:  i_b = WIDTH'(1);
            M_LUCAS: begin i_a = WIDTH'(2); i_b = WIDTH'(1); end
            M_PAD:   begin
                i_a = WIDTH'(1);
                i_b = WIDTH'(1);
                i_c = WIDTH'(1);
            end
            M_SYL:   begin i_a = WIDTH'(2); i_b = WIDTH'(3); end
            default: ;
        endcase
    end

    // Advance period minus one for each div_sel code
    always_comb begin
        case (sg.div_sel_i)
            4'd0:    pm1 = DIV_W'(0);
            4'd1:    pm1 = DIV_W'(1);
            4'd2:    pm1 = DIV_W'(4);
            4'd3:    pm1 = DIV_W'(9);
            4'd4:    pm1 = DIV_W'(19);
            4'd5:    pm1 = DIV_W'(49);
            4'd6:    pm1 = DIV_W'(99);
            4'd7:    pm1 = DIV_W'(199);
            4'd8:    pm1 = DIV_W'(499);
            4'd9:    pm1 = DIV_W'(999);
            4'd10:   pm1 = DIV_W'(1999);
            4'd11:   pm1 = DIV_W'(4999);
            4'd12:   pm1 = DIV_W'(9999);
            4'd13:   pm1 = DIV_W'(19999);
            4'd14:   pm1 = DIV_W'(99999);
            default: pm1 = DIV_W'(199999);
        endcase
    end

    assign bm1     = b_q - WIDTH'(1);
    assign tick    = sg.run_i & (cnt_q >= pm1);
    assign adv     = sg.run_i ? tick : sg.step_i;
    assign rst_seq = sg.restart_i | (sg.mode_i != mode_q);

    // Full-precision next term from the held truncated operands
    always_comb begin
        full = '0;
        case (mode_q)
            M_SQ:   full = FW'(a_q) + (FW'(idx_q) << 1) + FW'(1);
            M_POW3: full = FW'(a_q) * FW'(3);
            M_TRI:  full = FW'(a_q) + FW'(idx_q) + FW'(1);
            M_PELL: full = (FW'(b_q) << 1) + FW'(a_q);
            M_SYL:  full = FW'(b_q) * FW'(bm1) + FW'(1);
            default: full = FW'(a_q) + FW'(b_q);
        endcase
    end

    assign carry = |full[FW-1:WIDTH];

    // Next state: restart, divider and sequence advance; each queued
    // term carries its overflow flag until it becomes the visible value
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        fb_d    = fb_q;
        fc_d    = fc_q;
        idx_d   = idx_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
        cnt_d   = cnt_q;
        if (rst_seq) begin
            a_d   = i_a;
            b_d   = i_b;
            c_d   = i_c;
            fb_d  = 1'b0;
            fc_d  = 1'b0;
            idx_d = '0;
            ovf_d = 1'b0;
            cnt_d = '0;
        end else begin
            if (!sg.run_i || tick) cnt_d = '0;
            else                   cnt_d = cnt_q + DIV_W'(1);
            if (adv) begin
                valid_d = 1'b1;
                idx_d   = idx_q + WIDTH'(1);
                case (mode_q)
                    M_SQ, M_POW3, M_TRI: begin
                        a_d   = full[WIDTH-1:0];
                        ovf_d = ovf_q | carry;
                    end
                    M_PAD: begin
                        a_d   = b_q;
                        b_d   = c_q;
                        c_d   = full[WIDTH-1:0];
                        fb_d  = fc_q;
                        fc_d  = carry;
                        ovf_d = ovf_q | fb_q;
                    end
                    default: begin
                        a_d   = b_q;
                        b_d   = full[WIDTH-1:0];
                        fb_d  = carry;
                        ovf_d = ovf_q | fb_q;
                    end
                endcase
            end
        end
    end

    // State registers; reset loads term 0 of the mode on the pins
    always_ff @(posedge clk) begin
        mode_q <= sg.mode_i;
        if (reset) begin
            a_q     <= i_a;
            b_q     <= i_b;
            c_q     <= i_c;
            fb_q    <= 1'b0;
            fc_q    <= 1'b0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            fb_q    <= fb_d;
            fc_q    <= fc_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sg.value_o = a_q;
    assign sg.index_o = idx_q;
    assign sg.valid_o = valid_q;
    assign sg.ovf_o   = ovf_q;
endmodule

// File: tb/tb_seq_gen_core.sv
// Bench for seq_gen_core: directed scenarios with literal values plus
// random stimulus, checked each cycle against a term-list model.
`timescale 1ns/1ps
module tb_seq_gen_core;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;

    seq_gen_if #(.WIDTH(W)) sg ();

    seq_gen_core #(.WIDTH(W), .DIV_W(18)) dut (
        .clk  (clk),
        .reset(reset),
        .sg   (sg)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int         terms[$];
    bit         flags[$];
    int         m_n;
    int         m_cnt;
    bit         m_ovf;
    bit         m_valid;
    bit         m_ok = 1'b0;
    logic [2:0] m_mode;
    int periods[16] = '{1, 2, 5, 10, 20, 50, 100, 200, 500, 1000,
                        2000, 5000, 10000, 20000, 100000, 200000};

    function automatic void chk(string name, logic [31:0] got,
                                logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)",
                     name, got, exp, $time);
        end
    endfunction

    function automatic void seed(logic [2:0] m);
        terms.delete();
        flags.delete();
        case (m)
            3'd0: terms = '{0};
            3'd1: terms = '{1};
            3'd2: terms = '{0};
            3'd3: terms = '{1, 1};
            3'd4: terms = '{0, 1};
            3'd5: terms = '{2, 1};
            3'd6: terms = '{1, 1, 1};
            default: terms = '{2, 3};
        endcase
        foreach (terms[i]) flags.push_back(1'b0);
        m_n    = 0;
        m_ovf  = 1'b0;
        m_cnt  = 0;
        m_mode = m;
    endfunction

    // Extend the term list with the mathematical recurrence of each mode
    function automatic void grow(int k);
        int j;
        int p1;
        int raw;
        while (terms.size() <= k) begin
            j  = terms.size();
            p1 = terms[j-1];
            case (m_mode)
                3'd0: raw = p1 + 2 * ((j - 1) % 256) + 1;
                3'd1: raw = 3 * p1;
                3'd2: raw = p1 + ((j - 1) % 256) + 1;
                3'd3, 3'd5: raw = p1 + terms[j-2];
                3'd4: raw = 2 * p1 + terms[j-2];
                3'd6: raw = terms[j-2] + terms[j-3];
                default: raw = p1 * ((p1 + 255) % 256) + 1;
            endcase
            terms.push_back(raw % 256);
            flags.push_back(raw >= 256);
        end
    endfunction

    function automatic void model_step();
        bit tk;
        bit adv;
        if (reset || sg.restart_i || sg.mode_i != m_mode) begin
            seed(sg.mode_i);
            m_valid = 1'b0;
            m_ok    = 1'b1;
        end else begin
            tk = 1'b0;
            if (!sg.run_i) begin
                m_cnt = 0;
            end else if (m_cnt + 1 >= periods[sg.div_sel_i]) begin
                tk    = 1'b1;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
            adv     = sg.run_i ? tk : sg.step_i;
            m_valid = adv;
            if (adv) begin
                m_n++;
                grow(m_n);
                m_ovf = m_ovf | flags[m_n];
            end
        end
    endfunction

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (m_ok) begin
            chk("value", sg.value_o, terms[m_n]);
            chk("index", sg.index_o, m_n % 256);
            chk("valid", sg.valid_o, m_valid);
            chk("ovf",   sg.ovf_o,   m_ovf);
        end
    end

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic wait_valid(input int lim, output int c);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!sg.valid_o && c < lim);
    endtask

    int syl_v[4] = '{3, 7, 43, 15};
    int pw_v[7]  = '{1, 3, 9, 27, 81, 243, 217};
    int pel_v[8] = '{1, 2, 5, 12, 29, 70, 169, 152};

    initial begin
        int c;
        sg.mode_i    = 3'd0;
        sg.div_sel_i = 4'd0;
        sg.run_i     = 1'b0;
        sg.step_i    = 1'b0;
        sg.restart_i = 1'b0;
        cyc(2);
        chk("rst value", sg.value_o, 0);
        chk("rst index", sg.index_o, 0);
        chk("rst valid", sg.valid_o, 0);
        chk("rst ovf",   sg.ovf_o,   0);

        sg.mode_i = 3'd3;
        sg.run_i  = 1'b1;
        cyc(1);
        chk("fib t0", sg.value_o, 1);
        reset = 1'b0;
        cyc(12);
        chk("fib v12", sg.value_o, 233);
        chk("fib i12", sg.index_o, 12);
        chk("fib valid", sg.valid_o, 1);
        cyc(1);
        chk("fib v13", sg.value_o, 121);
        chk("fib ovf13", sg.ovf_o, 1);

        sg.mode_i = 3'd7;
        sg.run_i  = 1'b0;
        cyc(1);
        chk("syl t0", sg.value_o, 2);
        chk("syl ovf0", sg.ovf_o, 0);
        for (int k = 0; k < 4; k++) begin
            sg.step_i = 1'b1;
            cyc(1);
            sg.step_i = 1'b0;
            chk("syl val", sg.value_o, syl_v[k]);
            chk("syl ovf", sg.ovf_o, (k == 3) ? 1 : 0);
            cyc(1);
        end

        sg.mode_i    = 3'd1;
        sg.run_i     = 1'b1;
        sg.div_sel_i = 4'd2;
        cyc(1);
        chk("pow3 t0", sg.value_o, 1);
        for (int k = 1; k <= 6; k++) begin
            wait_valid(8, c);
            chk("pow3 gap", c, 5);
            chk("pow3 val", sg.value_o, pw_v[k]);
            chk("pow3 idx", sg.index_o, k);
            chk("pow3 ovf", sg.ovf_o, (k == 6) ? 1 : 0);
        end

        sg.mode_i    = 3'd6;
        sg.div_sel_i = 4'd0;
        cyc(7);
        sg.mode_i = 3'd4;
        cyc(1);
        chk("pell v0", sg.value_o, 0);
        chk("pell i0", sg.index_o, 0);
        chk("pell ovf0", sg.ovf_o, 0);
        chk("pell valid0", sg.valid_o, 0);
        for (int k = 1; k <= 8; k++) begin
            cyc(1);
            chk("pell val", sg.value_o, pel_v[k-1]);
            chk("pell ovf", sg.ovf_o, (k == 8) ? 1 : 0);
        end

        sg.mode_i = 3'd0;
        cyc(16);
        chk("sq v15", sg.value_o, 225);
        chk("sq ovf15", sg.ovf_o, 0);
        cyc(1);
        chk("sq v16", sg.value_o, 0);
        chk("sq ovf16", sg.ovf_o, 1);
        cyc(240);
        chk("sq wrap idx", sg.index_o, 0);
        chk("sq wrap ovf", sg.ovf_o, 1);
        cyc(3);

        sg.run_i     = 1'b0;
        sg.step_i    = 1'b1;
        sg.restart_i = 1'b1;
        cyc(1);
        sg.step_i    = 1'b0;
        sg.restart_i = 1'b0;
        chk("rs valid", sg.valid_o, 0);
        chk("rs index", sg.index_o, 0);

        sg.div_sel_i = 4'd3;
        sg.run_i     = 1'b1;
        cyc(7);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("mid rst index", sg.index_o, 0);
        chk("mid rst valid", sg.valid_o, 0);
        wait_valid(20, c);
        chk("first tick", c, 10);

        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 299) == 0);
            sg.restart_i = ($urandom_range(0, 59) == 0);
            sg.step_i    = $urandom_range(0, 1);
            if ($urandom_range(0, 99) == 0)
                sg.mode_i = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 39) == 0)
                sg.div_sel_i = 4'($urandom_range(0, 4));
            if ($urandom_range(0, 49) == 0)
                sg.run_i = ~sg.run_i;
            cyc(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/seq_gen_core.md
# seq_gen_core

Parametrised single-clock integer-sequence generator; the next-generation core of the sequence-generator tile. It produces one of eight classic sequences, selected by `mode`, modulo 2^WIDTH, advancing on an internal clock-enable divider or on a manual step pulse. It adds three things the tile needs: a term index, a sticky overflow flag and an update-valid pulse. It sits between the pin decode (`mode`, `div_sel`, `run`, `step`, `restart`) and the output pin mux.

## Interface
- WIDTH, 8, term/index width in bits (≥4)
- DIV_W, 18, divider counter width; must hold 199999

- clk  in  1  clock; all logic on posedge, no derived clocks
- reset  in  1  reset, synchronous, active-high
- mode  in  3  sequence select: 0 squares, 1 powers of 3, 2 triangular, 3 Fibonacci, 4 Pell, 5 Lucas, 6 Padovan, 7 Sylvester
- div_sel  in  4  advance period P in clk cycles: 1,2,5,10,20,50,100,200,500,1000,2000,5000,10000,20000,100000,200000 for codes 0..15
- run  in  1  1 = free-run on divider tick; 0 = manual stepping
- step  in  1  manual advance; honoured only when run=0, once per cycle it is high
- restart  in  1  return to term 0
- value  out  WIDTH  current term mod 2^WIDTH, registered
- index  out  WIDTH  current term number n, registered, wraps 2^WIDTH-1 → 0 silently
- valid  out  1  one-cycle pulse: value/index changed by an advance this cycle
- ovf  out  1  sticky overflow flag

## Operation
- Term 0 per mode: sq 0; pow3 1; tri 0; fib 1 (next 1); pell 0 (next 1); lucas 2 (next 1); padovan 1,1,1; sylvester 2 (next 3).
- Update rules, evaluated on the held WIDTH-bit state:
  - sq: s += 2n+1.
  - pow3: p *= 3.
  - tri: t += n+1.
  - fib/lucas: (a,b) → (b, a+b).
  - pell: (a,b) → (b, 2b+a).
  - padovan: (a,b,c) → (b, c, a+b).
  - sylvester: (a,b) → (b, b·(b−1)+1).
- Results are truncated to WIDTH bits; `value` = a.
- advance = (run & tick) | (~run & step).
- Divider: counter cleared while run=0. While run=1, tick is high when count ≥ P−1, and count then resets to 0; otherwise count increments. P=1 gives a tick every cycle. A div_sel change takes effect immediately, with no reset of count.
- ovf: set on an advance whose full-precision result is ≥ 2^WIDTH. The result is the sum or product of the held truncated operands, with products taken at 2·WIDTH bits. For sq/tri, ovf is also set by the n+1 carry. Once set, ovf stays set until restart or reset. Index wrap does not set ovf.
- A change of `mode` against the registered active mode is treated as restart.
- Priority: reset > restart/mode change > advance.
- Restart: state ← term 0 of the new mode, index ← 0, ovf ← 0, divider count ← 0, valid ← 0.

## Timing
- Reset values: value = term 0 of the current `mode` (0 for mode 0), index 0, valid 0, ovf 0, count 0; active mode ← `mode`.
- Advance decided in cycle k → new value, index and ovf visible, with valid=1, in cycle k+1.
- Restart/mode change in cycle k → term 0 visible in k+1, valid=0. An advance in the same cycle is dropped.
- Free-run with period P: valid pulses exactly every P cycles; the first pulse comes P cycles after run rises.
- Manual mode: a step held high N cycles gives N advances.
- A step while run=1 is ignored.
- Reset mid-divide discards the partial count.
- Exact `mode` is sampled every cycle.

## Test plan
- WIDTH=8, mode 3, div_sel 0, run 1 after reset → values 1,1,2,3,5,…,233 at index 12. At index 13: value 121, ovf=1. valid high every cycle.
- mode 7, run 0, four single-cycle steps → values 2,3,7,43,15. ovf rises with value 15 at index 4.
- mode 1, free-run div_sel 2 (P=5) → valid every 5th cycle with values 1,3,9,27,81,243,217. ovf set at index 6; index increments by 1 per pulse.
- mode 6 running, switch to mode 4 mid-sequence → next cycle value 0, index 0, ovf 0, valid 0. Then 1,2,5,12,29,70,169,152 with ovf at index 8.
- mode 0, div_sel 0, run 260 cycles → value n² mod 256. ovf set when index reaches 16 (value 0). Index wraps 255→0 with ovf unchanged.
- restart and step high in same cycle → term 0, no valid. reset asserted mid-run with div_sel 3 → all outputs at reset values next cycle, first tick 10 cycles after release.
